// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC and fetches one word per request over a req/ack handshake.
// It computes the next PC from jump, branch and JR controls once the back end retires the instruction.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                Jump,
    input  logic                JumpSel,
    input  logic                Branch,
    input  logic                alu_zero,
    input  logic [31:0]         reg_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                misalign
);

    // state | meaning
    // IDLE  | one cycle after reset release, no request outstanding
    // REQ   | request to memory at pc, waiting for ack
    // HOLD  | instr valid, waiting for back end to retire it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                misalign_q, misalign_d;
    logic [PC_WIDTH-1:0] next_pc;
    logic [31:0]         br_offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump outranks Branch; JR drops the low two bits and flags them separately.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump && JumpSel) begin
            next_pc = {reg_target[31:2], 2'b00};
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && !alu_zero) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = REQ;
                    if (Jump && JumpSel && (reg_target[1:0] != 2'b00)) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign misalign    = misalign_q;

endmodule
